// File: rtl/hnoc_pkg.sv
// Shared constants, flit layout and field helpers for the hnoc four-port switch.
package hnoc_pkg;

    localparam int NUM_PE   = 4;
    localparam int DATA_W   = 32;
    localparam int DEST_MSB = 31;
    localparam int DEST_LSB = 30;
    localparam int SRC_MSB  = 29;
    localparam int SRC_LSB  = 28;

    typedef struct packed {
        logic [1:0]  dest;
        logic [1:0]  src;
        logic [27:0] payload;
    } flit_t;

    function automatic logic [1:0] flit_dest(input logic [DATA_W-1:0] flit);
        return flit[DEST_MSB:DEST_LSB];
    endfunction

endpackage

// File: rtl/hnoc_in_fifo.sv
// Per-input synchronous FIFO for hnoc; full is registered and doubles as the
// inverted input-ready, so it is held high through reset.
module hnoc_in_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              full_q;
    logic              push_ok, pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // A pop on a full edge frees a slot, but the input only reopens one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/hnoc.sv
// hnoc: four-port single-flit switch, per-input FIFOs, per-output round-robin and output register.
// Define HNOC_PKT_COUNT_EN to add o_rx_count, the wrapping total of delivered flits.
module hnoc #(
    parameter int DATA_W     = hnoc_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_pe_data0,
    input  logic [DATA_W-1:0] i_pe_data1,
    input  logic [DATA_W-1:0] i_pe_data2,
    input  logic [DATA_W-1:0] i_pe_data3,
    input  logic              i_pe_data_valid0,
    input  logic              i_pe_data_valid1,
    input  logic              i_pe_data_valid2,
    input  logic              i_pe_data_valid3,
    output logic              o_pe_data_ready0,
    output logic              o_pe_data_ready1,
    output logic              o_pe_data_ready2,
    output logic              o_pe_data_ready3,
    output logic [DATA_W-1:0] o_pe_data0,
    output logic [DATA_W-1:0] o_pe_data1,
    output logic [DATA_W-1:0] o_pe_data2,
    output logic [DATA_W-1:0] o_pe_data3,
    output logic              o_pe_data_valid0,
    output logic              o_pe_data_valid1,
    output logic              o_pe_data_valid2,
    output logic              o_pe_data_valid3,
    input  logic              i_pe_data_ready0,
    input  logic              i_pe_data_ready1,
    input  logic              i_pe_data_ready2,
    input  logic              i_pe_data_ready3
`ifdef HNOC_PKT_COUNT_EN
    ,
    output logic [31:0]       o_rx_count
`endif
);

    import hnoc_pkg::*;

    logic [DATA_W-1:0] in_data    [NUM_PE];
    logic [NUM_PE-1:0] in_valid;
    logic [NUM_PE-1:0] out_ready;
    logic [DATA_W-1:0] head       [NUM_PE];
    logic [NUM_PE-1:0] fifo_full, fifo_empty, fifo_pop;

    logic [DATA_W-1:0] out_data_q [NUM_PE];
    logic [DATA_W-1:0] out_data_d [NUM_PE];
    logic [NUM_PE-1:0] out_valid_q, out_valid_d;
    logic [1:0]        rr_ptr_q   [NUM_PE];
    logic [1:0]        rr_ptr_d   [NUM_PE];

    logic              found;
    logic [1:0]        sel, cand;

    assign in_data[0] = i_pe_data0;
    assign in_data[1] = i_pe_data1;
    assign in_data[2] = i_pe_data2;
    assign in_data[3] = i_pe_data3;
    assign in_valid   = {i_pe_data_valid3, i_pe_data_valid2, i_pe_data_valid1, i_pe_data_valid0};
    assign out_ready  = {i_pe_data_ready3, i_pe_data_ready2, i_pe_data_ready1, i_pe_data_ready0};

    for (genvar g = 0; g < NUM_PE; g++) begin : g_in
        hnoc_in_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (in_valid[g]),
            .pop_i   (fifo_pop[g]),
            .data_i  (in_data[g]),
            .head_o  (head[g]),
            .full_o  (fifo_full[g]),
            .empty_o (fifo_empty[g])
        );
    end

    // Each head has one destination, so at most one output pops a given FIFO.
    always_comb begin
        fifo_pop    = '0;
        out_valid_d = out_valid_q;
        found       = 1'b0;
        sel         = '0;
        cand        = '0;
        for (int m = 0; m < NUM_PE; m++) begin
            out_data_d[m] = out_data_q[m];
            rr_ptr_d[m]   = rr_ptr_q[m];
            found         = 1'b0;
            sel           = rr_ptr_q[m];
            for (int k = 1; k <= NUM_PE; k++) begin
                cand = rr_ptr_q[m] + 2'(k);
                if (!found && !fifo_empty[cand] && (flit_dest(head[cand]) == 2'(m))) begin
                    found = 1'b1;
                    sel   = cand;
                end
            end
            if (!out_valid_q[m] || out_ready[m]) begin
                out_valid_d[m] = found;
                if (found) begin
                    out_data_d[m] = head[sel];
                    rr_ptr_d[m]   = sel;
                    fifo_pop[sel] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= '0;
            for (int m = 0; m < NUM_PE; m++) begin
                out_data_q[m] <= '0;
                rr_ptr_q[m]   <= 2'(NUM_PE - 1);
            end
        end else begin
            out_valid_q <= out_valid_d;
            for (int m = 0; m < NUM_PE; m++) begin
                out_data_q[m] <= out_data_d[m];
                rr_ptr_q[m]   <= rr_ptr_d[m];
            end
        end
    end

    assign o_pe_data_ready0 = !fifo_full[0];
    assign o_pe_data_ready1 = !fifo_full[1];
    assign o_pe_data_ready2 = !fifo_full[2];
    assign o_pe_data_ready3 = !fifo_full[3];
    assign o_pe_data0       = out_data_q[0];
    assign o_pe_data1       = out_data_q[1];
    assign o_pe_data2       = out_data_q[2];
    assign o_pe_data3       = out_data_q[3];
    assign o_pe_data_valid0 = out_valid_q[0];
    assign o_pe_data_valid1 = out_valid_q[1];
    assign o_pe_data_valid2 = out_valid_q[2];
    assign o_pe_data_valid3 = out_valid_q[3];

`ifdef HNOC_PKT_COUNT_EN
    logic [31:0] rx_count_q, rx_count_d;

    always_comb begin
        rx_count_d = rx_count_q;
        for (int m = 0; m < NUM_PE; m++) begin
            rx_count_d = rx_count_d + 32'(out_valid_q[m] & out_ready[m]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_count_q <= '0;
        end else begin
            rx_count_q <= rx_count_d;
        end
    end

    assign o_rx_count = rx_count_q;
`endif

endmodule

// File: tb/tb_hnoc.sv
// Self-checking bench for hnoc: directed cases plus randomized traffic against a
// per-(source,destination) ordering scoreboard.
module tb_hnoc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data [4];
    logic [3:0]  in_valid = '0;
    logic [3:0]  out_rdy  = '0;
    wire  [3:0]  o_ready;
    wire  [31:0] out_data [4];
    wire  [3:0]  out_valid;
`ifdef HNOC_PKT_COUNT_EN
    wire  [31:0] rx_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int hs_total = 0;
    int delivered = 0;
    bit sb_en = 1'b0;
    logic [31:0] exp_q [16][$];

    always #5 clk = ~clk;

    hnoc dut (
        .clk              (clk),
        .rst              (rst),
        .i_pe_data0       (in_data[0]),
        .i_pe_data1       (in_data[1]),
        .i_pe_data2       (in_data[2]),
        .i_pe_data3       (in_data[3]),
        .i_pe_data_valid0 (in_valid[0]),
        .i_pe_data_valid1 (in_valid[1]),
        .i_pe_data_valid2 (in_valid[2]),
        .i_pe_data_valid3 (in_valid[3]),
        .o_pe_data_ready0 (o_ready[0]),
        .o_pe_data_ready1 (o_ready[1]),
        .o_pe_data_ready2 (o_ready[2]),
        .o_pe_data_ready3 (o_ready[3]),
        .o_pe_data0       (out_data[0]),
        .o_pe_data1       (out_data[1]),
        .o_pe_data2       (out_data[2]),
        .o_pe_data3       (out_data[3]),
        .o_pe_data_valid0 (out_valid[0]),
        .o_pe_data_valid1 (out_valid[1]),
        .o_pe_data_valid2 (out_valid[2]),
        .o_pe_data_valid3 (out_valid[3]),
        .i_pe_data_ready0 (out_rdy[0]),
        .i_pe_data_ready1 (out_rdy[1]),
        .i_pe_data_ready2 (out_rdy[2]),
        .i_pe_data_ready3 (out_rdy[3])
`ifdef HNOC_PKT_COUNT_EN
        ,
        .o_rx_count       (rx_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mkflit(input int dest, input int src, input int payload);
        logic [31:0] f;
        f = {2'(dest), 2'(src), 28'(payload)};
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshakes observed just before each edge; inputs are stable from #1 after the previous edge.
    always @(negedge clk) begin
        if (rst) begin
            hs_total = 0;
        end else begin
            for (int m = 0; m < 4; m++) begin
                if (out_valid[m] === 1'b1 && out_rdy[m] === 1'b1) begin
                    hs_total++;
                    if (sb_en) begin
                        int s;
                        s = int'(out_data[m][29:28]);
                        chk("sb_dest", 64'(out_data[m][31:30]), 64'(m));
                        chk("sb_pending", 64'(exp_q[s*4+m].size() > 0), 64'd1);
                        if (exp_q[s*4+m].size() > 0) begin
                            chk("sb_order", 64'(out_data[m]), 64'(exp_q[s*4+m].pop_front()));
                        end
                        delivered++;
                    end
                end
            end
            if (sb_en) begin
                for (int n = 0; n < 4; n++) begin
                    if (in_valid[n] === 1'b1 && o_ready[n] === 1'b1) begin
                        exp_q[n*4 + int'(in_data[n][31:30])].push_back(in_data[n]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] f;
        int acc;
        bit stable_ok;
        bit any_valid;
        int sent [4];
        bit accd [4];
        int cyc;
        int leftover;

        for (int n = 0; n < 4; n++) in_data[n] = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_ready", 64'(o_ready), 64'h0);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_data2", 64'(out_data[2]), 64'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 64'(o_ready), 64'hf);
`ifdef HNOC_PKT_COUNT_EN
        chk("rst_rx_count", 64'(rx_count), 64'd0);
`endif

        // Single flit PE0 -> PE2, one cycle latency
        out_rdy = 4'hf;
        in_data[0] = 32'h8000_0123;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        chk("t1_not_yet", 64'(out_valid), 64'h0);
        tick();
        chk("t1_valid2", 64'(out_valid[2]), 64'd1);
        chk("t1_data2", 64'(out_data[2]), 64'h8000_0123);
        chk("t1_others", 64'(out_valid & 4'b1011), 64'h0);
        tick();
        chk("t1_gone", 64'(out_valid), 64'h0);

        // Four sources to dest 1 at once: round-robin 0,1,2,3, twice
        for (int r = 0; r < 2; r++) begin
            for (int n = 0; n < 4; n++) begin
                in_data[n] = mkflit(1, n, 'h100 + r*16 + n);
                in_valid[n] = 1'b1;
            end
            tick();
            in_valid = '0;
            for (int n = 0; n < 4; n++) begin
                tick();
                chk("t2_valid", 64'(out_valid[1]), 64'd1);
                chk("t2_order", 64'(out_data[1]), 64'(mkflit(1, n, 'h100 + r*16 + n)));
            end
        end
        tick();
        chk("t2_drained", 64'(out_valid), 64'h0);
`ifdef HNOC_PKT_COUNT_EN
        chk("t2_rx_count", 64'(rx_count), 64'(hs_total));
`endif

        // Stalled dest 3 while PE2 streams: FIFO_DEPTH + 1 flits buffered
        out_rdy[3] = 1'b0;
        acc = 0;
        stable_ok = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bit was;
            in_data[2] = mkflit(3, 2, 'h500 + acc);
            in_valid[2] = 1'b1;
            was = o_ready[2];
            tick();
            if (was) acc++;
            if (out_valid[3] === 1'b1 && out_data[3] !== mkflit(3, 2, 'h500)) stable_ok = 1'b0;
        end
        in_valid[2] = 1'b0;
        chk("t3_accepted", 64'(acc), 64'd5);
        chk("t3_ready_low", 64'(o_ready[2]), 64'd0);
        chk("t3_held_valid", 64'(out_valid[3]), 64'd1);
        chk("t3_stable", 64'(stable_ok), 64'd1);
        out_rdy[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_drain", 64'(out_data[3]), 64'(mkflit(3, 2, 'h500 + i)));
            tick();
        end
        chk("t3_empty", 64'(out_valid[3]), 64'd0);
        chk("t3_ready_back", 64'(o_ready[2]), 64'd1);

        // Loopback
        f = mkflit(1, 1, 'hABC);
        in_data[1] = f;
        in_valid[1] = 1'b1;
        tick();
        in_valid[1] = 1'b0;
        tick();
        chk("t4_loop_valid", 64'(out_valid[1]), 64'd1);
        chk("t4_loop_data", 64'(out_data[1]), 64'(f));
        tick();

        // Reset with flits in flight
        out_rdy = '0;
        in_data[0] = mkflit(2, 0, 'h11);
        in_data[1] = mkflit(3, 1, 'h22);
        in_data[2] = mkflit(0, 2, 'h33);
        in_valid = 4'b0111;
        tick();
        in_valid = '0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("t5_rst_ready", 64'(o_ready), 64'h0);
        chk("t5_rst_valid", 64'(out_valid), 64'h0);
        rst = 1'b0;
        tick();
        chk("t5_ready", 64'(o_ready), 64'hf);
        out_rdy = 4'hf;
        any_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 4'h0) any_valid = 1'b1;
            tick();
        end
        chk("t5_no_valid", 64'(any_valid), 64'd0);

        // Random traffic, 100 flits per source, random output stalls
        sb_en = 1'b1;
        for (int n = 0; n < 4; n++) sent[n] = 0;
        cyc = 0;
        while (((sent[0] + sent[1] + sent[2] + sent[3]) < 400) && cyc < 8000) begin
            for (int n = 0; n < 4; n++) begin
                if (!in_valid[n] && sent[n] < 100 && $urandom_range(0, 3) != 0) begin
                    in_data[n] = mkflit($urandom_range(0, 3), n, n*1000 + sent[n]);
                    in_valid[n] = 1'b1;
                end
            end
            for (int m = 0; m < 4; m++) out_rdy[m] = ($urandom_range(0, 3) != 0);
            for (int n = 0; n < 4; n++) accd[n] = in_valid[n] && o_ready[n];
            tick();
            for (int n = 0; n < 4; n++) begin
                if (accd[n]) begin
                    sent[n]++;
                    in_valid[n] = 1'b0;
                end
            end
            cyc++;
        end
        in_valid = '0;
        out_rdy = 4'hf;
        cyc = 0;
        while (delivered < 400 && cyc < 500) begin
            tick();
            cyc++;
        end
        repeat (2) tick();
        chk("rand_sent", 64'(sent[0] + sent[1] + sent[2] + sent[3]), 64'd400);
        chk("rand_delivered", 64'(delivered), 64'd400);
        leftover = 0;
        for (int i = 0; i < 16; i++) leftover += exp_q[i].size();
        chk("rand_leftover", 64'(leftover), 64'd0);
        chk("rand_idle", 64'(out_valid), 64'h0);
`ifdef HNOC_PKT_COUNT_EN
        chk("rand_rx_count", 64'(rx_count), 64'd400);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
